uart_rx: RTL and testbench

//  8N1 UART receiver, LSB first; counterpart of uart_tx on the pc_one serial link.

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first.
// A 2-FF synchroniser and falling-edge detector feed a four-state framing FSM.
// Bytes land in a one-byte holding register with valid, framing-error and
// overrun status flags.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       read_en,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;
  logic             w_fall;
  logic             w_deliver;
  logic             w_ferr_set;

  assign w_fall = r_prev & ~r_sync2;

  // Synchroniser and edge-detect history; all load 1 (idle line) on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Framing FSM state, bit timing counter, bit index and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state decode; also raises one-cycle deliver / framing-error strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_deliver     = 1'b0;
    w_ferr_set    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt   = S_START;
          w_bit_cnt_nxt = '0;
        end
      end
      S_START: begin
        if (r_bit_cnt == CNT_HALF) begin
          w_bit_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = r_sync2 ? S_IDLE : S_DATA;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_bit_cnt == CNT_FULL) begin
          w_bit_cnt_nxt          = '0;
          w_shift_nxt[r_bit_idx] = r_sync2;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_bit_cnt == CNT_FULL) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_IDLE;
          w_deliver     = r_sync2;
          w_ferr_set    = ~r_sync2;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Holding register and status flags; a same-cycle deliver/error beats read_en
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_deliver && (!r_valid || read_en)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (read_en) begin
        r_valid <= 1'b0;
      end

      if (w_ferr_set) begin
        r_ferr <= 1'b1;
      end else if (read_en) begin
        r_ferr <= 1'b0;
      end

      if (w_deliver && r_valid && !read_en) begin
        r_ovr <= 1'b1;
      end else if (read_en) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign data_out  = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx (16 clks/bit) and compares
// the status outputs against a frame-level reference model of the receiver.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       read_en;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model: holding register and flags, updated once per whole frame
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ferr;
  logic       m_ovr;

  uart_rx #(
    .CLK_FREQ (1600),
    .BAUD_RATE(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .read_en  (read_en),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_read();
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // One complete frame; rd = read_en coincided with the stop-bit sample
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic rd);
    if (stop) begin
      if (rd) begin
        m_data  = b;
        m_valid = 1'b1;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
      end else if (!m_valid) begin
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
      if (rd) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_read();
    read_en = 1'b1;
    @(posedge clk);
    #1;
    read_en = 1'b0;
  endtask

  // Serialise one frame, starting just after a rising edge. mode 1 pulses
  // read_en on the stop-sample cycle; mode 2 checks rx_valid timing around it
  // (caller guarantees rx_valid was 0 beforehand).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned mode);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop;
    if (mode == 0) begin
      repeat (CPB) @(posedge clk);
      #1;
    end else begin
      repeat (CPB - 6) @(posedge clk);
      #1;
      if (mode == 1) read_en = 1'b1;
      if (mode == 2) begin
        n_vec++;
        if ({rx_valid, rx_busy} !== 2'b01) begin
          n_err++;
          $display("FAIL latency_before {valid,busy}: got %b, expected 01", {rx_valid, rx_busy});
        end
      end
      @(posedge clk);
      #1;
      read_en = 1'b0;
      if (mode == 2) begin
        n_vec++;
        if ({rx_valid, rx_busy} !== 2'b10) begin
          n_err++;
          $display("FAIL latency_after {valid,busy}: got %b, expected 10", {rx_valid, rx_busy});
        end
      end
      repeat (5) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    rx      = 1'b1;
    read_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_vec++;
    if ({data_out, rx_valid, frame_err, overrun, rx_busy} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_state: got %h/%b%b%b%b, expected 00/0000",
               data_out, rx_valid, frame_err, overrun, rx_busy);
    end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_basic();
    send_frame(8'h55, 1'b1, 2);
    model_frame(8'h55, 1'b1, 1'b0);
    n_vec++;
    if ({data_out, rx_valid, frame_err, overrun, rx_busy} !== {m_data, m_valid, m_ferr, m_ovr, 1'b0}) begin
      n_err++;
      $display("FAIL basic_0x55: got %h/%b%b%b%b, expected %h/%b%b%b0",
               data_out, rx_valid, frame_err, overrun, rx_busy, m_data, m_valid, m_ferr, m_ovr);
    end
    pulse_read();
    model_read();
    idle(4);
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (rx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_busy: got %b, expected 1", rx_busy);
    end
    idle(20);
    n_vec++;
    if ({data_out, rx_valid, frame_err, overrun, rx_busy} !== {m_data, m_valid, m_ferr, m_ovr, 1'b0}) begin
      n_err++;
      $display("FAIL glitch_idle: got %h/%b%b%b%b, expected %h/%b%b%b0",
               data_out, rx_valid, frame_err, overrun, rx_busy, m_data, m_valid, m_ferr, m_ovr);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'hA3, 1'b0, 0);
    model_frame(8'hA3, 1'b0, 1'b0);
    repeat (40 - CPB) @(posedge clk);
    #1;
    n_vec++;
    if ({data_out, rx_valid, frame_err, overrun, rx_busy} !== {m_data, m_valid, m_ferr, m_ovr, 1'b0}) begin
      n_err++;
      $display("FAIL frame_err_held_low: got %h/%b%b%b%b, expected %h/%b%b%b0",
               data_out, rx_valid, frame_err, overrun, rx_busy, m_data, m_valid, m_ferr, m_ovr);
    end
    idle(6);
    pulse_read();
    model_read();
    n_vec++;
    if ({rx_valid, frame_err, overrun} !== 3'b000) begin
      n_err++;
      $display("FAIL frame_err_clear: got %b, expected 000", {rx_valid, frame_err, overrun});
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h12, 1'b1, 0);
    model_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 0);
    model_frame(8'h34, 1'b1, 1'b0);
    n_vec++;
    if ({data_out, rx_valid, frame_err, overrun, rx_busy} !== {m_data, m_valid, m_ferr, m_ovr, 1'b0}) begin
      n_err++;
      $display("FAIL overrun_set: got %h/%b%b%b%b, expected %h/%b%b%b0",
               data_out, rx_valid, frame_err, overrun, rx_busy, m_data, m_valid, m_ferr, m_ovr);
    end
    pulse_read();
    model_read();
    n_vec++;
    if ({data_out, rx_valid, overrun} !== {m_data, m_valid, m_ovr}) begin
      n_err++;
      $display("FAIL overrun_read: got %h/%b%b, expected %h/%b%b",
               data_out, rx_valid, overrun, m_data, m_valid, m_ovr);
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    send_frame(8'h12, 1'b1, 0);
    model_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1);
    model_frame(8'h34, 1'b1, 1'b1);
    n_vec++;
    if ({data_out, rx_valid, frame_err, overrun, rx_busy} !== {m_data, m_valid, m_ferr, m_ovr, 1'b0}) begin
      n_err++;
      $display("FAIL read_on_deliver: got %h/%b%b%b%b, expected %h/%b%b%b0",
               data_out, rx_valid, frame_err, overrun, rx_busy, m_data, m_valid, m_ferr, m_ovr);
    end
    pulse_read();
    model_read();
    idle(4);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'hC7;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = b[3];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_vec++;
    if ({data_out, rx_valid, frame_err, overrun, rx_busy} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_mid_frame: got %h/%b%b%b%b, expected 00/0000",
               data_out, rx_valid, frame_err, overrun, rx_busy);
    end
    rst = 1'b0;
    idle(20);
    send_frame(8'hF0, 1'b1, 0);
    model_frame(8'hF0, 1'b1, 1'b0);
    n_vec++;
    if ({data_out, rx_valid, frame_err, overrun, rx_busy} !== {m_data, m_valid, m_ferr, m_ovr, 1'b0}) begin
      n_err++;
      $display("FAIL after_reset_0xF0: got %h/%b%b%b%b, expected %h/%b%b%b0",
               data_out, rx_valid, frame_err, overrun, rx_busy, m_data, m_valid, m_ferr, m_ovr);
    end
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic        stop;
    int unsigned mode;
    int unsigned gap;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(2) == 0) begin
        pulse_read();
        model_read();
      end
      b    = 8'($urandom);
      stop = ($urandom_range(4) != 0);
      mode = ($urandom_range(3) == 0) ? 1 : 0;
      send_frame(b, stop, mode);
      model_frame(b, stop, (mode == 1));
      n_vec++;
      if ({data_out, rx_valid, frame_err, overrun, rx_busy} !== {m_data, m_valid, m_ferr, m_ovr, 1'b0}) begin
        n_err++;
        $display("FAIL random_frame_%0d: got %h/%b%b%b%b, expected %h/%b%b%b0",
                 i, data_out, rx_valid, frame_err, overrun, rx_busy, m_data, m_valid, m_ferr, m_ovr);
      end
      gap = stop ? $urandom_range(3) : 4 + $urandom_range(3);
      if (gap != 0) idle(gap);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    rx      = 1'b1;
    read_en = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    pulse_read();
    model_read();
    idle(4);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
